// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: ALU_OP encodings and FSM state encoding shared by the
// alu_iter top and its iterative datapath.
package alu_iter_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_iter_seq.sv
// alu_iter_seq: iterative shift / shift-add multiply datapath.
// A down-counter loaded with the iteration count paces the work. One step is
// taken on the load edge itself, so an operation needing k steps is finished
// after k edges. last_o flags that the step taken on the coming edge is the
// final one, and res_o is the value that step produces.
// The multiplier (multiplier register and accumulator) exists only when
// ALU_ITER_MUL_EN is defined.
module alu_iter_seq
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  alu_op_e          op_i,
`ifdef ALU_ITER_MUL_EN
  input  logic [WIDTH-1:0] b_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o
);

  logic [CNT_W-1:0] cnt_q, cnt_cur;
  logic [WIDTH-1:0] sh_q, sh_cur, sh_nxt;
  alu_op_e          op_q, op_cur;
`ifdef ALU_ITER_MUL_EN
  logic [WIDTH-1:0] mp_q, mp_cur, mp_nxt;
  logic [WIDTH-1:0] acc_q, acc_cur, acc_nxt;
`endif

  // Select fresh operands on load, otherwise the running registers; compute one step.
  always_comb begin
    op_cur  = load_i ? op_i  : op_q;
    sh_cur  = load_i ? a_i   : sh_q;
    cnt_cur = load_i ? cnt_i : cnt_q;
    sh_nxt  = sh_cur;
    case (op_cur)
      OP_SLL:  sh_nxt = {sh_cur[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_nxt = {1'b0, sh_cur[WIDTH-1:1]};
      OP_SRA:  sh_nxt = {sh_cur[WIDTH-1], sh_cur[WIDTH-1:1]};
`ifdef ALU_ITER_MUL_EN
      OP_MUL:  sh_nxt = {sh_cur[WIDTH-2:0], 1'b0};
`endif
      default: sh_nxt = sh_cur;
    endcase
    res_o  = sh_nxt;
`ifdef ALU_ITER_MUL_EN
    // sh holds the shifted multiplicand; mp is consumed LSB-first.
    mp_cur  = load_i ? b_i : mp_q;
    acc_cur = load_i ? '0  : acc_q;
    acc_nxt = acc_cur + (mp_cur[0] ? sh_cur : '0);
    mp_nxt  = {1'b0, mp_cur[WIDTH-1:1]};
    if (op_cur == OP_MUL) res_o = acc_nxt;
`endif
    last_o = (cnt_cur == CNT_W'(1));
  end

  // Iteration registers advance on load and on every busy step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sh_q  <= '0;
      op_q  <= OP_ADD;
`ifdef ALU_ITER_MUL_EN
      mp_q  <= '0;
      acc_q <= '0;
`endif
    end else if (load_i || step_i) begin
      cnt_q <= cnt_cur - CNT_W'(1);
      sh_q  <= sh_nxt;
      op_q  <= op_cur;
`ifdef ALU_ITER_MUL_EN
      mp_q  <= mp_nxt;
      acc_q <= acc_nxt;
`endif
    end
  end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU with single-cycle ADD/SUB/AND/OR and iterative
// shifts (one bit per cycle). Defining ALU_ITER_MUL_EN adds an iterative
// unsigned multiply on ALU_OP 111; otherwise that opcode returns zero.
//
//   state  | meaning
//   S_IDLE | ready for a request (In_Ready=1)
//   S_BUSY | iterative shift/multiply in progress
//   S_DONE | result presented (Out_Valid=1) until Out_Ready
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Read_Data,
  input  logic [WIDTH-1:0] PC_Out,
  input  logic             Branch,
  input  logic [WIDTH-1:0] Imm_Extend,
  input  logic [2:0]       ALU_OP,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Ans,
  output logic             Zero,
  output logic             Carry
);

  // Counter must hold both WIDTH (multiply) and the largest shift amount.
  localparam int CNT_W = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             zero_q, zero_d, carry_q, carry_d;

  logic [WIDTH-1:0] a_sel, single_res, add_s, seq_res;
  logic             add_c, single_c, is_iter, seq_load, seq_step, seq_last;
  logic [SHAMT_W-1:0] k;
  logic [CNT_W-1:0] seq_cnt;
  alu_op_e          op;

  // Operand mux and single-cycle results.
  always_comb begin
    a_sel          = Branch ? PC_Out : Read_Data;
    op             = alu_op_e'(ALU_OP);
    k              = Imm_Extend[SHAMT_W-1:0];
    {add_c, add_s} = {1'b0, a_sel} + {1'b0, Imm_Extend};
    single_res     = '0;
    single_c       = 1'b0;
    case (op)
      OP_ADD: begin single_res = add_s; single_c = add_c; end
      OP_SUB: begin single_res = a_sel - Imm_Extend; single_c = (a_sel >= Imm_Extend); end
      OP_AND: single_res = a_sel & Imm_Extend;
      OP_OR:  single_res = a_sel | Imm_Extend;
      OP_SLL, OP_SRL, OP_SRA: single_res = a_sel;  // zero shift amount
      default: single_res = '0;                     // MUL when not built in
    endcase
    is_iter = (op inside {OP_SLL, OP_SRL, OP_SRA}) && (k != '0);
`ifdef ALU_ITER_MUL_EN
    if (op == OP_MUL) is_iter = 1'b1;
`endif
    seq_cnt = (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(k);
  end

  alu_iter_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .load_i (seq_load),
    .step_i (seq_step),
    .op_i   (op),
`ifdef ALU_ITER_MUL_EN
    .b_i    (Imm_Extend),
`endif
    .a_i    (a_sel),
    .cnt_i  (seq_cnt),
    .last_o (seq_last),
    .res_o  (seq_res)
  );

  // Next-state and result-register logic.
  always_comb begin
    state_d  = state_q;
    ans_d    = ans_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (In_Valid) begin
          if (is_iter) begin
            seq_load = 1'b1;
            carry_d  = 1'b0;
            if (seq_last) begin
              state_d = S_DONE;
              ans_d   = seq_res;
              zero_d  = (seq_res == '0);
            end else begin
              state_d = S_BUSY;
            end
          end else begin
            state_d = S_DONE;
            ans_d   = single_res;
            zero_d  = (single_res == '0);
            carry_d = single_c;
          end
        end
      end
      S_BUSY: begin
        seq_step = 1'b1;
        if (seq_last) begin
          state_d = S_DONE;
          ans_d   = seq_res;
          zero_d  = (seq_res == '0);
          carry_d = 1'b0;
        end
      end
      S_DONE: begin
        if (Out_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ans_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ans_q   <= ans_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign In_Ready  = (state_q == S_IDLE);
  assign Out_Valid = (state_q == S_DONE);
  assign Ans       = ans_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vector table plus hold and mid-operation reset sequences
// for alu_iter at WIDTH=8. Expectations follow ALU_ITER_MUL_EN.
module tb_alu_iter;

  logic       clk = 1'b0;
  logic       reset, In_Valid, In_Ready, Branch, Out_Valid, Out_Ready, Zero, Carry;
  logic [7:0] Read_Data, PC_Out, Imm_Extend, Ans;
  logic [2:0] ALU_OP;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       branch;
    logic [7:0] rd;
    logic [7:0] pc;
    logic [7:0] imm;
    logic [2:0] op;
    logic [7:0] ans;
    logic       zero;
    logic       carry;
    int         lat;
  } vec_t;

  vec_t vecs[16];

  alu_iter #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Read_Data  (Read_Data),
    .PC_Out     (PC_Out),
    .Branch     (Branch),
    .Imm_Extend (Imm_Extend),
    .ALU_OP     (ALU_OP),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Ans        (Ans),
    .Zero       (Zero),
    .Carry      (Carry)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    Read_Data  = 8'($urandom);
    PC_Out     = 8'($urandom);
    Imm_Extend = 8'($urandom);
    ALU_OP     = 3'($urandom);
    Branch     = 1'($urandom);
  endtask

  // Issue one request, ignore-test In_Valid while busy, measure latency in
  // cycles (cycle 1 = the cycle after the capture edge), check and accept.
  task automatic run_vec(input vec_t v, input int idx);
    int c;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready_idle", idx), 32'(In_Ready), 32'd1);
    Branch = v.branch; Read_Data = v.rd; PC_Out = v.pc; Imm_Extend = v.imm;
    ALU_OP = v.op; In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c = 1;
    scramble();
    while (!Out_Valid && c < 40) begin
      @(negedge clk);
      c++;
      scramble();
    end
    chk($sformatf("v%0d_latency", idx), 32'(c), 32'(v.lat));
    chk($sformatf("v%0d_ans", idx), 32'(Ans), 32'(v.ans));
    chk($sformatf("v%0d_zero", idx), 32'(Zero), 32'(v.zero));
    chk($sformatf("v%0d_carry", idx), 32'(Carry), 32'(v.carry));
    chk($sformatf("v%0d_in_ready_done", idx), 32'(In_Ready), 32'd0);
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_accept_out_valid", idx), 32'(Out_Valid), 32'd0);
    chk($sformatf("v%0d_accept_in_ready", idx), 32'(In_Ready), 32'd1);
    Out_Ready = 1'b0;
  endtask

  initial begin
    int c;
    int stale;
    //          br    rd     pc     imm    op      ans    z     c     lat
    vecs[0]  = '{1'b0, 8'h7F, 8'h00, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b1, 8'h55, 8'h10, 8'hF8, 3'b000, 8'h08, 1'b0, 1'b1, 1};
    vecs[2]  = '{1'b0, 8'h05, 8'h99, 8'h05, 3'b001, 8'h00, 1'b1, 1'b1, 1};
    vecs[3]  = '{1'b0, 8'h03, 8'h00, 8'h05, 3'b001, 8'hFE, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, 8'hF0, 8'h00, 8'h3C, 3'b101, 8'h30, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b0, 8'hA0, 8'h00, 8'h05, 3'b110, 8'hA5, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, 8'h03, 8'h00, 8'h05, 3'b010, 8'h60, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b0, 8'h80, 8'h00, 8'h03, 3'b100, 8'hF0, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'h03, 8'h00, 8'h08, 3'b010, 8'h03, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 8'h80, 8'h00, 8'h03, 3'b011, 8'h10, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 8'h81, 8'h00, 8'h01, 3'b011, 8'h40, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b0, 8'h40, 8'h00, 8'h07, 3'b100, 8'h00, 1'b1, 1'b0, 7};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1};
    vecs[13] = '{1'b1, 8'h00, 8'h81, 8'h01, 3'b010, 8'h02, 1'b0, 1'b0, 1};
`ifdef ALU_ITER_MUL_EN
    vecs[14] = '{1'b0, 8'h0D, 8'h00, 8'h0B, 3'b111, 8'h8F, 1'b0, 1'b0, 8};
    vecs[15] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 3'b111, 8'h01, 1'b0, 1'b0, 8};
`else
    vecs[14] = '{1'b0, 8'h0D, 8'h00, 8'h0B, 3'b111, 8'h00, 1'b1, 1'b0, 1};
    vecs[15] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 3'b111, 8'h00, 1'b1, 1'b0, 1};
`endif

    reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
    Branch = 1'b0; Read_Data = '0; PC_Out = '0; Imm_Extend = '0; ALU_OP = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ans", 32'(Ans), 32'h0);
    chk("rst_zero", 32'(Zero), 32'd0);
    chk("rst_carry", 32'(Carry), 32'd0);
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_in_ready", 32'(In_Ready), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Result held while Out_Ready stays low for three cycles.
    @(negedge clk);
    Branch = 1'b0; Read_Data = 8'h7F; Imm_Extend = 8'h01; ALU_OP = 3'b000; In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    chk("hold_first_valid", 32'(Out_Valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      scramble();
      In_Valid = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d_state", i), {28'd0, Out_Valid, In_Ready, Zero, Carry}, {28'd0, 4'b1000});
      chk($sformatf("hold%0d_ans", i), 32'(Ans), 32'h80);
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", 32'(In_Ready), 32'd1);
    chk("hold_release_out_valid", 32'(Out_Valid), 32'd0);
    Out_Ready = 1'b0;

    // Reset at cycle N+4 of a multiply aborts it with no late result.
    @(negedge clk);
    Branch = 1'b0; Read_Data = 8'h0D; Imm_Extend = 8'h0B; ALU_OP = 3'b111; In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    c = 1;
    while (c < 4) begin
      @(negedge clk);
      c++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", 32'(Out_Valid), 32'd0);
    chk("abort_in_ready", 32'(In_Ready), 32'd1);
    chk("abort_ans", 32'(Ans), 32'h0);
    chk("abort_flags", {30'd0, Zero, Carry}, 32'd0);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) stale++;
    end
    chk("abort_no_stale_result", 32'(stale), 32'd0);

    run_vec(vecs[7], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 8: datapath width in bits (legal range 4..32).
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): shift-amount field width, taken from Imm_Extend[SHAMT_W-1:0].
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 In_Valid  input  1  operation request valid.
REQ-006 In_Ready  output  1  block can accept a request; high only in IDLE.
REQ-007 Read_Data  input  WIDTH  register operand, used as operand A when Branch=0.
REQ-008 PC_Out  input  WIDTH  program counter, used as operand A when Branch=1.
REQ-009 Branch  input  1  operand-A select.
REQ-010 Imm_Extend  input  WIDTH  operand B.
REQ-011 ALU_OP  input  3  000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 AND, 110 OR, 111 MUL.
REQ-012 Out_Valid  output  1  result valid; held until accepted.
REQ-013 Out_Ready  input  1  consumer accepts the result.
REQ-014 Ans  output  WIDTH  registered result.
REQ-015 Zero  output  1  Ans == 0, registered with Ans.
REQ-016 Carry  output  1  ADD carry-out; SUB 1 when A >= B unsigned; 0 for all other ops.

Function
REQ-017 FSM states IDLE, BUSY, DONE; In_Valid && In_Ready captures A (per Branch), B, ALU_OP at that edge (cycle N).
REQ-018 ADD, SUB, AND, OR: IDLE->DONE; Out_Valid high at cycle N+1.
REQ-019 SLL/SRL/SRA, shift amount k = Imm_Extend[SHAMT_W-1:0]: k=0 -> IDLE->DONE, Ans=A at N+1; k>=1 -> IDLE->BUSY, one bit shifted per cycle, Out_Valid at N+k.
REQ-020 SRA replicates A[WIDTH-1]; SRL and SLL fill with 0.
REQ-021 MUL: iterative shift-add over WIDTH cycles, Out_Valid at N+WIDTH, Ans = low WIDTH bits of the unsigned product.
REQ-022 ADD/SUB wrap modulo 2^WIDTH.
REQ-023 DONE: Ans, Zero, Carry, Out_Valid held stable until Out_Valid && Out_Ready, then -> IDLE next cycle.
REQ-024 In_Ready is low in BUSY and DONE; In_Valid there is ignored; inputs may change freely after capture.
REQ-025 Out_Valid and In_Ready are never high in the same cycle.

Reset
REQ-026 reset high at a clock edge -> state IDLE, Ans=0, Zero=0, Carry=0, Out_Valid=0, In_Ready=1 on the next cycle, regardless of state.
REQ-027 Reset aborts any in-flight operation; no result for it is ever presented.

Configuration
REQ-028 Macro ALU_ITER_MUL_EN defined: ALU_OP 111 performs MUL per REQ-021.
REQ-029 ALU_ITER_MUL_EN undefined: no multiplier logic; ALU_OP 111 -> IDLE->DONE, Ans=0, Zero=1, Carry=0 at N+1.

Structure
REQ-030 Package alu_iter_pkg holds the ALU_OP encodings and the FSM state enum.
REQ-031 Sub-module alu_iter_seq holds the iterative shift/multiply datapath (counter, shift register, accumulator); alu_iter holds the FSM, operand mux and single-cycle ops.

Verification (WIDTH=8)
REQ-032 ADD, Branch=0, Read_Data=0x7F, Imm_Extend=0x01 -> Ans=0x80, Carry=0, Zero=0, Out_Valid at N+1.
REQ-033 ADD, Branch=1, PC_Out=0x10, Imm_Extend=0xF8 -> Ans=0x08, Carry=1; SUB 0x05-0x05 -> Ans=0x00, Zero=1, Carry=1.
REQ-034 SLL, A=0x03, Imm=0x05 -> Ans=0x60 at N+5; SRA, A=0x80, Imm=0x03 -> Ans=0xF0 at N+3; SLL, Imm=0x08 (k=0) -> Ans=0x03 at N+1.
REQ-035 MUL 0x0D x 0x0B -> Ans=0x8F at N+8 with macro; Ans=0x00, Zero=1 at N+1 without.
REQ-036 Out_Ready low 3 cycles in DONE -> Ans, flags stable, In_Ready=0; Out_Ready high -> In_Ready=1 next cycle.
REQ-037 reset pulsed at cycle N+4 of MUL -> next cycle Out_Valid=0, In_Ready=1, Ans=0; no stale result afterwards.
